mnk_game_engine: RTL

Parametrised m,n,k-game referee, generalising the team's 3x3 tic-tac-toe block to a BOARD_N x BOARD_N board with a WIN_K-in-a-row win rule.
- Enforces turn order, legal coordinates and empty-cell placement through a valid/ready move handshake.
- Runs a sequential win/draw scan after every legal move.
- Sits between the player-input encoders and the board display/LED driver.

---
 rtl/mnk_pkg.sv | 38 +++
 rtl/mnk_line_checker.sv | 55 +++++
 rtl/mnk_game_engine.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mnk_pkg.sv
// mnk_pkg: shared definitions for the m,n,k-game referee.
//   - cell codes stored in the flat board vector
//   - illegal_code values reported on a rejected move
//   - referee FSM state encoding
//   - width helpers for coordinates, scan index and move counter
package mnk_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;

    localparam logic [1:0] ILL_NONE     = 2'b00;
    localparam logic [1:0] ILL_TURN     = 2'b01;
    localparam logic [1:0] ILL_RANGE    = 2'b10;
    localparam logic [1:0] ILL_OCCUPIED = 2'b11;

    typedef enum logic [1:0] {
        TURN  = 2'd0,
        CHECK = 2'd1,
        OVER  = 2'd2
    } state_t;

    // Width of a row/column coordinate for an n x n board.
    function automatic int coord_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Width of the anchor scan index 0 .. n*n-1.
    function automatic int idx_w(input int n);
        return $clog2(n * n);
    endfunction

    // Width of the move counter 0 .. n*n.
    function automatic int count_w(input int n);
        return $clog2(n * n + 1);
    endfunction

endpackage

// File: rtl/mnk_line_checker.sv
// mnk_line_checker: combinational WIN_K-in-a-row detector for one anchor cell.
// Ports:
//   board       flat board, cell (r,c) at [2*(r*BOARD_N+c) +: 2]
//   anchor_row  anchor row
//   anchor_col  anchor column
//   player      code of the player whose lines are tested
//   hit         1 when a run of WIN_K cells equal to player starts at the
//               anchor in the row, column, diagonal or anti-diagonal direction
module mnk_line_checker
    import mnk_pkg::*;
#(
    parameter int BOARD_N = 3,
    parameter int WIN_K   = 3,
    localparam int CW     = coord_w(BOARD_N),
    localparam int BW     = 2 * BOARD_N * BOARD_N
) (
    input  logic [BW-1:0] board,
    input  logic [CW-1:0] anchor_row,
    input  logic [CW-1:0] anchor_col,
    input  logic [1:0]    player,
    output logic          hit
);

    // Cells off the board read as empty; since player is never the empty
    // code, any run that would leave the board fails to match naturally.
    function automatic logic [1:0] cell_at(input logic [BW-1:0] b, input int rr, input int cc);
        if (rr >= 0 && rr < BOARD_N && cc >= 0 && cc < BOARD_N)
            return b[2*(rr*BOARD_N+cc) +: 2];
        else
            return CELL_EMPTY;
    endfunction

    always_comb begin
        int  r;
        int  c;
        logic run_h;
        logic run_v;
        logic run_d;
        logic run_a;
        r     = int'(anchor_row);
        c     = int'(anchor_col);
        run_h = 1'b1;
        run_v = 1'b1;
        run_d = 1'b1;
        run_a = 1'b1;
        for (int i = 0; i < WIN_K; i++) begin
            if (cell_at(board, r,     c + i) != player) run_h = 1'b0;
            if (cell_at(board, r + i, c    ) != player) run_v = 1'b0;
            if (cell_at(board, r + i, c + i) != player) run_d = 1'b0;
            if (cell_at(board, r + i, c - i) != player) run_a = 1'b0;
        end
        hit = run_h | run_v | run_d | run_a;
    end

endmodule

// File: rtl/mnk_game_engine.sv
// mnk_game_engine: BOARD_N x BOARD_N, WIN_K-in-a-row game referee.
// Validates moves offered on a valid/ready handshake, places legal moves and
// then scans every anchor cell (one per cycle) for a win or a draw.
// Optional feature macro: MNK_TURN_TIMEOUT_EN (per-turn forfeit after
// TIMEOUT_CYCLES idle cycles in TURN); without it timeout is tied low.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   new_game             synchronous clear to the post-reset state
//   move_valid/ready     move handshake; ready only while waiting for a move
//   move_player          0=P1, 1=P2
//   move_row/move_col    0-based coordinates
//   board                flat board, 2 bits per cell
//   turn                 player to move
//   move_count           legal moves placed
//   illegal_move         one-cycle pulse on a rejected move
//   illegal_code         reason of the last rejection
//   over/winner/draw     registered game result
//   timeout              one-cycle pulse when a turn is forfeited
module mnk_game_engine
    import mnk_pkg::*;
#(
    parameter int BOARD_N        = 3,
    parameter int WIN_K          = 3,
    parameter int TIMEOUT_CYCLES = 1000000,
    localparam int CW            = coord_w(BOARD_N),
    localparam int MW            = count_w(BOARD_N),
    localparam int BW            = 2 * BOARD_N * BOARD_N
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          new_game,
    input  logic          move_valid,
    output logic          move_ready,
    input  logic          move_player,
    input  logic [CW-1:0] move_row,
    input  logic [CW-1:0] move_col,
    output logic [BW-1:0] board,
    output logic          turn,
    output logic [MW-1:0] move_count,
    output logic          illegal_move,
    output logic [1:0]    illegal_code,
    output logic          over,
    output logic [1:0]    winner,
    output logic          draw,
    output logic          timeout
);

    localparam int              CELLS      = BOARD_N * BOARD_N;
    localparam int              IW         = idx_w(BOARD_N);
    localparam logic [CW:0]     N_EXT      = (CW+1)'(BOARD_N);
    localparam logic [IW-1:0]   LAST_IDX   = IW'(CELLS - 1);
    localparam logic [MW-1:0]   FULL_COUNT = MW'(CELLS);
    localparam logic [CW-1:0]   LAST_COL   = CW'(BOARD_N - 1);

    state_t        state_q, state_d;
    logic [BW-1:0] board_q;
    logic          turn_q;
    logic [MW-1:0] move_count_q;
    logic [IW-1:0] idx_q;
    logic [CW-1:0] scan_row_q;
    logic [CW-1:0] scan_col_q;
    logic          over_q;
    logic [1:0]    winner_q;
    logic          draw_q;
    logic          illegal_move_q;
    logic [1:0]    illegal_code_q;

    logic          in_range;
    logic          occupied;
    int            cell_sel;
    logic [1:0]    mover_code;
    logic          line_hit;
    logic          accept_legal;
    logic          reject;
    logic [1:0]    reject_code;
    logic          set_win;
    logic          set_draw;
    logic          end_turn;
    logic          forfeit;

    // During CHECK the turn has not toggled yet, so the current turn is the
    // mover; in TURN a legal move always comes from the current turn too.
    assign mover_code = turn_q ? CELL_P2 : CELL_P1;

    // The widened compare keeps row == BOARD_N representable when BOARD_N
    // is a power of two.
    assign in_range = ({1'b0, move_row} < N_EXT) && ({1'b0, move_col} < N_EXT);

    always_comb begin
        cell_sel = int'(move_row) * BOARD_N + int'(move_col);
        occupied = in_range && (board_q[2*cell_sel +: 2] != CELL_EMPTY);
    end

    mnk_line_checker #(
        .BOARD_N (BOARD_N),
        .WIN_K   (WIN_K)
    ) u_line_checker (
        .board      (board_q),
        .anchor_row (scan_row_q),
        .anchor_col (scan_col_q),
        .player     (mover_code),
        .hit        (line_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= TURN;
        else
            state_q <= state_d;
    end

    // Next state plus the one-cycle strobes that steer the datapath.
    always_comb begin
        state_d      = state_q;
        accept_legal = 1'b0;
        reject       = 1'b0;
        reject_code  = ILL_NONE;
        set_win      = 1'b0;
        set_draw     = 1'b0;
        end_turn     = 1'b0;
        case (state_q)
            TURN: begin
                if (move_valid) begin
                    if (!in_range) begin
                        reject      = 1'b1;
                        reject_code = ILL_RANGE;
                    end else if (move_player != turn_q) begin
                        reject      = 1'b1;
                        reject_code = ILL_TURN;
                    end else if (occupied) begin
                        reject      = 1'b1;
                        reject_code = ILL_OCCUPIED;
                    end else begin
                        accept_legal = 1'b1;
                        state_d      = CHECK;
                    end
                end
            end
            CHECK: begin
                if (line_hit) begin
                    set_win = 1'b1;
                    state_d = OVER;
                end else if (idx_q == LAST_IDX) begin
                    if (move_count_q == FULL_COUNT) begin
                        set_draw = 1'b1;
                        state_d  = OVER;
                    end else begin
                        end_turn = 1'b1;
                        state_d  = TURN;
                    end
                end
            end
            OVER: begin
                state_d = OVER;
            end
            default: begin
                state_d = TURN;
            end
        endcase
        if (new_game)
            state_d = TURN;
    end

    // Board, counters, scan position and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            board_q        <= '0;
            turn_q         <= 1'b0;
            move_count_q   <= '0;
            idx_q          <= '0;
            scan_row_q     <= '0;
            scan_col_q     <= '0;
            over_q         <= 1'b0;
            winner_q       <= CELL_EMPTY;
            draw_q         <= 1'b0;
            illegal_move_q <= 1'b0;
            illegal_code_q <= ILL_NONE;
        end else if (new_game) begin
            board_q        <= '0;
            turn_q         <= 1'b0;
            move_count_q   <= '0;
            idx_q          <= '0;
            scan_row_q     <= '0;
            scan_col_q     <= '0;
            over_q         <= 1'b0;
            winner_q       <= CELL_EMPTY;
            draw_q         <= 1'b0;
            illegal_move_q <= 1'b0;
            illegal_code_q <= ILL_NONE;
        end else begin
            illegal_move_q <= reject;
            if (reject)
                illegal_code_q <= reject_code;
            if (accept_legal) begin
                board_q[2*cell_sel +: 2] <= mover_code;
                move_count_q             <= move_count_q + MW'(1);
                idx_q                    <= '0;
                scan_row_q               <= '0;
                scan_col_q               <= '0;
            end else if (state_q == CHECK) begin
                // Row/column are tracked alongside idx to avoid a divider.
                idx_q <= idx_q + IW'(1);
                if (scan_col_q == LAST_COL) begin
                    scan_col_q <= '0;
                    scan_row_q <= scan_row_q + CW'(1);
                end else begin
                    scan_col_q <= scan_col_q + CW'(1);
                end
            end
            if (set_win) begin
                over_q   <= 1'b1;
                winner_q <= mover_code;
            end
            if (set_draw) begin
                over_q   <= 1'b1;
                draw_q   <= 1'b1;
                winner_q <= CELL_EMPTY;
            end
            if (end_turn || forfeit)
                turn_q <= ~turn_q;
        end
    end

`ifdef MNK_TURN_TIMEOUT_EN
    localparam int            TW      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_cnt_q;
    logic          timeout_q;

    // A legal accept on the expiry edge takes precedence over the forfeit.
    assign forfeit = (state_q == TURN) && (to_cnt_q == TO_LAST) && !accept_legal;

    // Idle counter for the player to move; rejected moves do not restart it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else if (new_game) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= forfeit;
            if (accept_legal || forfeit)
                to_cnt_q <= '0;
            else if (state_q == TURN)
                to_cnt_q <= to_cnt_q + TW'(1);
        end
    end

    assign timeout = timeout_q;
`else
    assign forfeit = 1'b0;
    assign timeout = 1'b0;
`endif

    assign move_ready   = (state_q == TURN);
    assign board        = board_q;
    assign turn         = turn_q;
    assign move_count   = move_count_q;
    assign illegal_move = illegal_move_q;
    assign illegal_code = illegal_code_q;
    assign over         = over_q;
    assign winner       = winner_q;
    assign draw         = draw_q;

endmodule
